// File: rtl/dtw_ref_stream_reader_if.sv
// Output stream bundle of the DTW reference reader: data, valid, last and
// the downstream ready that closes the handshake.
interface dtw_ref_stream_reader_if #(
    parameter int width = 16
);
    logic [width-1:0] m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/dtw_ref_stream_reader.sv
// Read-side engine for the DTW reference BRAM. Walks len addresses from
// base_addr, absorbs the 1-cycle BRAM read latency and presents the words as
// a valid/ready stream through a 2-entry buffer. Read issue is credit-based:
// buffered words plus the word in flight never exceed the buffer depth.
module dtw_ref_stream_reader #(
    parameter int width  = 16,
    parameter int ptrWid = 18
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ptrWid-1:0]   base_addr,
    input  logic [ptrWid:0]     len,
    output logic                busy,
    output logic                done,
    output logic [ptrWid-1:0]   mem_addr,
    input  logic [width-1:0]    mem_rdata,
    dtw_ref_stream_reader_if.master strm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [ptrWid:0]    remaining_reg;
    logic               inflight_reg;
    logic               inflight_last_reg;

    logic [width-1:0]   fifo_data_reg [2];
    logic               fifo_last_reg [2];
    logic [1:0]         fifo_count_reg;

    logic               fifo_valid;
    logic               pop;
    logic               push;
    logic [2:0]         occ_after_pop;
    logic               issue;
    logic               issue_last;

    assign fifo_valid    = (fifo_count_reg != 2'd0);
    assign pop           = fifo_valid & strm.m_ready;
    assign push          = inflight_reg;
    // Occupancy the buffer will have to absorb if a read is issued now:
    // what it holds, plus the word already on the BRAM output, minus a pop.
    assign occ_after_pop = {1'b0, fifo_count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign issue         = (state_reg == READ) && (occ_after_pop < 3'd2);
    assign issue_last    = issue && (remaining_reg == {{ptrWid{1'b0}}, 1'b1});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = (len == '0) ? DONE : READ;
            READ:    if (issue_last) state_next = DRAIN;
            DRAIN:   if (pop && fifo_last_reg[0]) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            READ, DRAIN: busy = 1'b1;
            DONE:        done = 1'b1;
            default:     ;
        endcase
    end

    // Address walk, remaining count and in-flight tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr          <= '0;
            remaining_reg     <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            inflight_reg      <= issue;
            inflight_last_reg <= issue_last;
            if (state_reg == IDLE && start) begin
                mem_addr      <= base_addr;
                remaining_reg <= len;
            end else if (issue) begin
                mem_addr      <= mem_addr + ptrWid'(1);
                remaining_reg <= remaining_reg - {{ptrWid{1'b0}}, 1'b1};
            end
        end
    end

    // Two-entry shift buffer; slot 0 is always the head so m_data only
    // moves on a pop or when a word lands in an empty buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data_reg[0] <= '0;
            fifo_data_reg[1] <= '0;
            fifo_last_reg[0] <= 1'b0;
            fifo_last_reg[1] <= 1'b0;
            fifo_count_reg   <= 2'd0;
        end else begin
            if (push && pop) begin
                if (fifo_count_reg == 2'd1) begin
                    fifo_data_reg[0] <= mem_rdata;
                    fifo_last_reg[0] <= inflight_last_reg;
                end else begin
                    fifo_data_reg[0] <= fifo_data_reg[1];
                    fifo_last_reg[0] <= fifo_last_reg[1];
                    fifo_data_reg[1] <= mem_rdata;
                    fifo_last_reg[1] <= inflight_last_reg;
                end
            end else if (push) begin
                if (fifo_count_reg == 2'd0) begin
                    fifo_data_reg[0] <= mem_rdata;
                    fifo_last_reg[0] <= inflight_last_reg;
                end else begin
                    fifo_data_reg[1] <= mem_rdata;
                    fifo_last_reg[1] <= inflight_last_reg;
                end
                fifo_count_reg <= fifo_count_reg + 2'd1;
            end else if (pop) begin
                fifo_data_reg[0] <= fifo_data_reg[1];
                fifo_last_reg[0] <= fifo_last_reg[1];
                fifo_count_reg   <= fifo_count_reg - 2'd1;
            end
        end
    end

    assign strm.m_data  = fifo_data_reg[0];
    assign strm.m_valid = fifo_valid;
    assign strm.m_last  = fifo_valid & fifo_last_reg[0];

endmodule

// File: tb/tb_dtw_ref_stream_reader.sv
// Self-checking bench for dtw_ref_stream_reader: a BRAM model plus a
// scoreboard that expects beat k of a transfer to carry MEM[(base+k) mod 2**18].
module tb_dtw_ref_stream_reader;
    localparam int W     = 16;
    localparam int P     = 18;
    localparam int DEPTH = 1 << P;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [P-1:0]  base_addr = '0;
    logic [P:0]    len = '0;
    logic          busy;
    logic          done;
    logic [P-1:0]  mem_addr;
    logic [W-1:0]  mem_rdata;
    logic [W-1:0]  mem [DEPTH];

    int pass_cnt  = 0;
    int total_cnt = 0;

    dtw_ref_stream_reader_if #(.width(W)) strm ();

    dtw_ref_stream_reader #(.width(W), .ptrWid(P)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .strm      (strm)
    );

    always #5 clk = ~clk;

    // BRAM with one cycle of registered read latency.
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    // One transfer. mode 0: m_ready always 1 with exact cycle timing checks;
    // mode 1: ready pattern 1,0,0,1; mode 2: random ready.
    // restart_at > 0 re-pulses start with new base/len at that cycle.
    task automatic stream_xfer(input logic [P-1:0] b, input int n, input int mode,
                               input int restart_at, input string tag);
        int beats = 0;
        int dones = 0;
        int done_cyc = -1;
        int limit;
        logic prev_stall = 1'b0;
        logic [W-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        logic [W-1:0] exp_data;
        logic exp_v, exp_b, exp_d;
        limit = (mode == 0) ? n + 6 : 8 * n + 40;
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        len = n[P:0];
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            base_addr = P'($urandom);
            len = (c == restart_at) ? (P+1)'($urandom_range(1, 9)) : (P+1)'($urandom_range(0, 30));
            case (mode)
                0:       strm.m_ready = 1'b1;
                1:       strm.m_ready = ((c % 4) == 1) || ((c % 4) == 0);
                default: strm.m_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 0) begin
                exp_v = (n != 0) && (c >= 3) && (c <= n + 2);
                exp_b = (n != 0) && (c >= 1) && (c <= n + 2);
                exp_d = (n == 0) ? (c == 1) : (c == n + 3);
                total_cnt++;
                if (strm.m_valid !== exp_v) $display("FAIL %s m_valid cyc %0d: got %b want %b", tag, c, strm.m_valid, exp_v);
                else pass_cnt++;
                total_cnt++;
                if (busy !== exp_b) $display("FAIL %s busy cyc %0d: got %b want %b", tag, c, busy, exp_b);
                else pass_cnt++;
                total_cnt++;
                if (done !== exp_d) $display("FAIL %s done cyc %0d: got %b want %b", tag, c, done, exp_d);
                else pass_cnt++;
                if (n != 0 && c <= n) begin
                    total_cnt++;
                    if (mem_addr !== P'(b + c - 1)) $display("FAIL %s mem_addr cyc %0d: got %h want %h", tag, c, mem_addr, P'(b + c - 1));
                    else pass_cnt++;
                end
            end else begin
                total_cnt++;
                if (dut.fifo_count_reg > 2'd2) $display("FAIL %s fifo_count cyc %0d: got %0d want <=2", tag, c, dut.fifo_count_reg);
                else pass_cnt++;
            end
            if (prev_stall) begin
                total_cnt++;
                if (strm.m_valid !== 1'b1 || strm.m_data !== prev_data || strm.m_last !== prev_last)
                    $display("FAIL %s stall_hold cyc %0d: got v%b %h/%b want v1 %h/%b", tag, c, strm.m_valid, strm.m_data, strm.m_last, prev_data, prev_last);
                else pass_cnt++;
            end
            if (strm.m_valid && strm.m_ready) begin
                exp_data = mem[P'(b + beats)];
                total_cnt++;
                if (beats >= n || strm.m_data !== exp_data || strm.m_last !== (beats == n - 1))
                    $display("FAIL %s beat %0d: got %h/%b want %h/%b (len %0d)", tag, beats, strm.m_data, strm.m_last, exp_data, (beats == n - 1), n);
                else pass_cnt++;
                beats++;
            end
            if (done) begin
                dones++;
                done_cyc = c;
                total_cnt++;
                if (beats !== n || strm.m_valid !== 1'b0) $display("FAIL %s done_point: got beats %0d valid %b want beats %0d valid 0", tag, beats, strm.m_valid, n);
                else pass_cnt++;
            end
            prev_stall = strm.m_valid && !strm.m_ready;
            prev_data  = strm.m_data;
            prev_last  = strm.m_last;
            if (mode != 0 && done_cyc >= 0 && c > done_cyc + 1) break;
        end
        start = 1'b0;
        total_cnt++;
        if (dones != 1 || beats != n) $display("FAIL %s completion: got done %0d beats %0d want done 1 beats %0d", tag, dones, beats, n);
        else pass_cnt++;
        $display("xfer %s base=%h len=%0d mode=%0d beats=%0d done_cyc=%0d", tag, b, n, mode, beats, done_cyc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        strm.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({busy, done, strm.m_valid, strm.m_last} !== 4'b0000 || strm.m_data !== '0 || mem_addr !== '0)
            $display("FAIL reset_state: got busy%b done%b v%b l%b data %h addr %h want all zero",
                     busy, done, strm.m_valid, strm.m_last, strm.m_data, mem_addr);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        $display("xfer reset checked");
    endtask

    task automatic test_basic();
        stream_xfer(P'(18'h00010), 4, 0, 0, "basic");
    endtask

    task automatic test_backpressure();
        stream_xfer(P'($urandom), 8, 1, 0, "backpressure");
    endtask

    task automatic test_wrap();
        stream_xfer(P'(DEPTH - 2), 4, 0, 0, "wrap");
    endtask

    task automatic test_zero_len();
        stream_xfer(P'($urandom), 0, 0, 0, "zero_len");
    endtask

    task automatic test_restart();
        stream_xfer(P'($urandom), 5, 0, 2, "restart");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1;
        base_addr = P'($urandom);
        len = (P+1)'(6);
        @(negedge clk);
        start = 1'b0;
        strm.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (strm.m_valid !== 1'b1 || busy !== 1'b1) $display("FAIL reset_mid pre: got v%b busy%b want v1 busy1", strm.m_valid, busy);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (strm.m_valid !== 1'b0 || busy !== 1'b0 || strm.m_last !== 1'b0)
            $display("FAIL reset_mid immediate: got v%b busy%b l%b want 0 0 0", strm.m_valid, busy, strm.m_last);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if (done !== 1'b0 || strm.m_valid !== 1'b0) $display("FAIL reset_mid hold %0d: got done%b v%b want 0 0", i, done, strm.m_valid);
            else pass_cnt++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("xfer reset_mid applied");
        stream_xfer(P'($urandom), 2, 0, 0, "post_reset");
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++)
            stream_xfer(P'($urandom), $urandom_range(1, 16), 2, 0, "random");
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom);
        strm.m_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_restart();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
